// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, latencies and FSM states.
package mdu_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MFHI  = 4'd7,
    MFLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // True for the ops that start a multi-cycle computation.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. The result is computed behaviourally at
// accept, held in a pending register, and committed after the fixed op latency.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic [31:0] mdu_out
);

  state_e      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] hi, lo;
  logic [63:0] pending;
  logic        pending_we;
  logic [63:0] result;
  logic        result_we;
  logic        accept;
  logic        commit;
  logic [3:0]  lat;

  assign busy   = (state == BUSY);
  assign accept = start && !req && (state == IDLE) && is_arith(mdu_op);
  assign lat    = ((mdu_op == MULT) || (mdu_op == MULTU)) ? 4'(MULT_LAT) : 4'(DIV_LAT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result    = '0;
    result_we = 1'b1;
    case (mdu_op)
      MULT:  result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      MULTU: result = {32'h0, a} * {32'h0, b};
      DIV: begin
        if (b == 32'h0) begin
          result_we = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // Quotient overflows; pin the architecturally defined answer.
          result = {32'h0, 32'h8000_0000};
        end else begin
          result = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
        end
      end
      DIVU: begin
        if (b == 32'h0) result_we = 1'b0;
        else            result    = {a % b, a / b};
      end
      default: result_we = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = lat;
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = IDLE;
          commit     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // mthi/mtlo can never collide with a commit: both are gated off while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi         <= '0;
      lo         <= '0;
      pending    <= '0;
      pending_we <= 1'b0;
    end else begin
      if (accept) begin
        pending    <= result;
        pending_we <= result_we;
      end
      if (commit) begin
        if (pending_we) {hi, lo} <= pending;
      end else if (!busy && !req) begin
        if (mdu_op == MTHI) hi <= a;
        if (mdu_op == MTLO) lo <= a;
      end
    end
  end

  always_comb begin
    mdu_out = '0;
    if (mdu_op == MFHI) mdu_out = hi;
    else if (mdu_op == MFLO) mdu_out = lo;
  end

endmodule
